// File: rtl/hdmi_out_pkg.sv
// Shared types and sizing constants for the HDMI output path. Used by the
// fill sequencer, fill_fifo_fsm and the FIFO sizing.
package hdmi_out_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } fill_state_e;

  localparam int unsigned BURST_LEN_W         = 16;
  localparam int unsigned DEF_BURST_BYTES     = 64;
  localparam int unsigned DEF_BURSTS_PER_FILL = 8;

  // Counter width for n values, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fill_burst_addr_gen.sv
// Burst address generator: holds the aligned address of the current burst
// and counts bursts within one fill.
module fill_burst_addr_gen
  import hdmi_out_pkg::*;
#(
  parameter int unsigned BURST_BYTES     = DEF_BURST_BYTES,
  parameter int unsigned BURSTS_PER_FILL = DEF_BURSTS_PER_FILL,
  parameter int unsigned ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int unsigned       CNT_W      = cnt_width(BURSTS_PER_FILL);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(BURST_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP - ADDR_W'(1));

  logic [CNT_W-1:0] burst_cnt;

  // Increment wraps modulo 2^ADDR_W on purpose.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr      <= '0;
      burst_cnt <= '0;
    end else if (load) begin
      addr      <= load_addr & ALIGN_MASK;
      burst_cnt <= '0;
    end else if (advance) begin
      addr      <= addr + STEP;
      burst_cnt <= burst_cnt + CNT_W'(1);
    end
  end

  assign last = (burst_cnt == CNT_W'(BURSTS_PER_FILL - 1));

endmodule

// File: rtl/fifo_fill_burst_ctrl.sv
// Refills the HDMI pixel FIFO: splits each fill request into fixed-size DDR
// read bursts, one outstanding at a time, with vsync abort and error tracking.
module fifo_fill_burst_ctrl
  import hdmi_out_pkg::*;
#(
  parameter int unsigned BURST_BYTES     = DEF_BURST_BYTES,
  parameter int unsigned BURSTS_PER_FILL = DEF_BURSTS_PER_FILL,
  parameter int unsigned ADDR_W          = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   fill_req,
  input  logic [ADDR_W-1:0]      fill_addr,
  input  logic                   frame_abort,
  output logic                   mst_rd_req,
  output logic [ADDR_W-1:0]      mst_rd_addr,
  output logic [BURST_LEN_W-1:0] mst_rd_len,
  input  logic                   mst_cmd_ack,
  input  logic                   mst_rd_done,
  input  logic                   mst_rd_err,
  output logic                   busy,
  output logic                   fill_done,
  output logic [7:0]             overrun_cnt,
  output logic                   err_sticky
);

  fill_state_e state;
  logic        abort_pend;
  logic        last_burst;
  logic        load;
  logic        advance;
  logic        abort_now;

  // A vsync coinciding with the burst's done pulse cancels the fill just
  // like an earlier one would have.
  assign abort_now = abort_pend | frame_abort;
  assign load      = (state == ST_IDLE) && fill_req && enable && !frame_abort;
  assign advance   = (state == ST_DATA) && mst_rd_done && !mst_rd_err
                     && !abort_now && !last_burst;

  fill_burst_addr_gen #(
    .BURST_BYTES    (BURST_BYTES),
    .BURSTS_PER_FILL(BURSTS_PER_FILL),
    .ADDR_W         (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_addr(fill_addr),
    .advance  (advance),
    .addr     (mst_rd_addr),
    .last     (last_burst)
  );

  assign mst_rd_len = BURST_LEN_W'(BURST_BYTES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      mst_rd_req <= 1'b0;
      busy       <= 1'b0;
      fill_done  <= 1'b0;
      err_sticky <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (load) begin
            state      <= ST_CMD;
            mst_rd_req <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_CMD: begin
          if (mst_cmd_ack) begin
            state      <= ST_DATA;
            mst_rd_req <= 1'b0;
            abort_pend <= frame_abort;
          end else if (frame_abort) begin
            state      <= ST_IDLE;
            mst_rd_req <= 1'b0;
            busy       <= 1'b0;
          end
        end
        ST_DATA: begin
          if (mst_rd_done) begin
            abort_pend <= 1'b0;
            if (mst_rd_err) begin
              err_sticky <= 1'b1;
              state      <= ST_IDLE;
              busy       <= 1'b0;
            end else if (abort_now) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else if (last_burst) begin
              state     <= ST_DONE;
              fill_done <= 1'b1;
            end else begin
              state      <= ST_CMD;
              mst_rd_req <= 1'b1;
            end
          end else if (frame_abort) begin
            abort_pend <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          mst_rd_req <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_cnt <= '0;
    end else if (fill_req && (state != ST_IDLE) && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

endmodule
